// File: rtl/current_limit_guard_if.sv
// Bus between the HPS/current-monitor side and the current limit guard.
// current_valid is a one-cycle qualifier: current_average is consumed on the edge where it is 1; there is no back-pressure.
interface current_limit_guard_if #(
  parameter int CURRENT_W = 32
);
  logic [CURRENT_W-1:0] current_average;
  logic                 current_valid;
  logic [1:0]           power_request;
  logic                 clear_latch;
  logic [1:0]           power_enable;
  logic                 tripped;
  logic [1:0]           retry_count;
  logic [2:0]           guard_state;

  modport master (
    output current_average, current_valid, power_request, clear_latch,
    input  power_enable, tripped, retry_count, guard_state
  );

  modport slave (
    input  current_average, current_valid, power_request, clear_latch,
    output power_enable, tripped, retry_count, guard_state
  );
endinterface

// File: rtl/current_limit_guard.sv
// Over-current guard: gates motor power enables, trips on sustained over-current,
// retries after a cooldown and latches off once the retry budget is spent.
module current_limit_guard #(
  parameter int                   CURRENT_W         = 32,
  parameter logic [CURRENT_W-1:0] TRIP_THRESHOLD    = CURRENT_W'(1000),
  parameter logic [CURRENT_W-1:0] RELEASE_THRESHOLD = CURRENT_W'(900),
  parameter int                   TRIP_CYCLES       = 50000,
  parameter int                   COOLDOWN_CYCLES   = 50000000,
  parameter int                   MAX_RETRIES       = 3
) (
  input logic                  clk,
  input logic                  reset,
  current_limit_guard_if.slave bus
);

  localparam int CNT_MAX = (TRIP_CYCLES > COOLDOWN_CYCLES) ? TRIP_CYCLES : COOLDOWN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TRIP_LAST = CNT_W'(TRIP_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [1:0]       RC_MAX    = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ON       = 3'd1,
    S_OVER     = 3'd2,
    S_COOLDOWN = 3'd3,
    S_LATCHED  = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       rc, rc_n;
  logic [1:0]       pe;
  logic             tr;
  logic             req_on, over, release_ok;

  assign req_on     = (bus.power_request != 2'b00);
  assign over       = bus.current_valid && (bus.current_average > TRIP_THRESHOLD);
  assign release_ok = bus.current_valid && (bus.current_average <= RELEASE_THRESHOLD);

  always_comb begin
    state_n = state;
    rc_n    = rc;
    cnt_n   = '0;
    case (state)
      S_IDLE: begin
        if (req_on) state_n = S_ON;
      end
      S_ON: begin
        if (!req_on) begin
          state_n = S_IDLE;
          rc_n    = 2'd0;
        end else if (over) begin
          state_n = S_OVER;
        end
      end
      S_OVER: begin
        // Request-off beats release, release beats trip.
        if (!req_on) begin
          state_n = S_IDLE;
          rc_n    = 2'd0;
        end else if (release_ok) begin
          state_n = S_ON;
        end else if (cnt == TRIP_LAST) begin
          if (rc == RC_MAX) begin
            state_n = S_LATCHED;
          end else begin
            state_n = S_COOLDOWN;
            rc_n    = rc + 2'd1;
          end
        end
      end
      S_COOLDOWN: begin
        if (cnt == COOL_LAST) state_n = S_IDLE;
      end
      S_LATCHED: begin
        if (bus.clear_latch) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // A clear always wins the retry count, even when it lands on a trip.
    if (bus.clear_latch) rc_n = 2'd0;

    if (state_n != state) cnt_n = '0;
    else if (state == S_OVER || state == S_COOLDOWN) cnt_n = cnt + CNT_W'(1);
    else cnt_n = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      rc    <= 2'd0;
      pe    <= 2'b00;
      tr    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rc    <= rc_n;
      pe    <= (state_n == S_ON || state_n == S_OVER) ? bus.power_request : 2'b00;
      tr    <= (state_n == S_LATCHED);
    end
  end

  assign bus.power_enable = pe;
  assign bus.tripped      = tr;
  assign bus.retry_count  = rc;
  assign bus.guard_state  = state;

endmodule

// File: tb/tb_current_limit_guard.sv
// Scenario bench for current_limit_guard with short trip/cooldown times.
module tb_current_limit_guard;

  localparam logic [2:0] IDLE = 3'd0, ON = 3'd1, OVER = 3'd2, COOL = 3'd3, LATCH = 3'd4;
  localparam logic [1:0] MAX_R = 2'd2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  current_limit_guard_if #(.CURRENT_W(32)) bus ();

  current_limit_guard #(
    .CURRENT_W(32),
    .TRIP_THRESHOLD(32'd1000),
    .RELEASE_THRESHOLD(32'd900),
    .TRIP_CYCLES(4),
    .COOLDOWN_CYCLES(8),
    .MAX_RETRIES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] expv(input logic [2:0] st, input logic [1:0] pe,
                                      input logic tr, input logic [1:0] rc);
    return {st, pe, tr, rc};
  endfunction

  function automatic logic [31:0] over_val();
    return 32'($urandom_range(5000, 1001));
  endfunction

  // Drive one cycle of stimulus, record the expected and the observed outputs.
  task automatic step(input logic [1:0] req, input logic vld, input logic [31:0] avg,
                      input logic clr, input logic rst, input logic [7:0] e);
    bus.power_request   = req;
    bus.current_valid   = vld;
    bus.current_average = avg;
    bus.clear_latch     = clr;
    reset               = rst;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    obs_q.push_back({bus.guard_state, bus.power_enable, bus.tripped, bus.retry_count});
  endtask

  // From ON: enter OVER, hold with samples in [lo,hi] for three cycles, trip on the fourth.
  task automatic trip_seq(input logic [1:0] rc_in, input logic clr_at_trip, input int lo, input int hi);
    logic [1:0] rc_c;
    step(2'b11, 1'b1, over_val(), 1'b0, 1'b0, expv(OVER, 2'b11, 1'b0, rc_in));
    for (int i = 0; i < 3; i++)
      step(2'b11, 1'b1, 32'($urandom_range(hi, lo)), 1'b0, 1'b0, expv(OVER, 2'b11, 1'b0, rc_in));
    if (rc_in == MAX_R) begin
      step(2'b11, 1'b0, 32'd0, clr_at_trip, 1'b0, expv(LATCH, 2'b00, 1'b1, clr_at_trip ? 2'd0 : rc_in));
    end else begin
      rc_c = clr_at_trip ? 2'd0 : rc_in + 2'd1;
      step(2'b11, 1'b0, 32'd0, clr_at_trip, 1'b0, expv(COOL, 2'b00, 1'b0, rc_c));
      for (int i = 0; i < 7; i++)
        step(2'b11, 1'b1, over_val(), 1'b0, 1'b0, expv(COOL, 2'b00, 1'b0, rc_c));
      step(2'b11, 1'b1, over_val(), 1'b0, 1'b0, expv(IDLE, 2'b00, 1'b0, rc_c));
      step(2'b11, 1'b0, 32'd0, 1'b0, 1'b0, expv(ON, 2'b11, 1'b0, rc_c));
    end
  endtask

  task automatic test_reset();
    logic [7:0] got, want;
    step(2'b11, 1'b1, over_val(), 1'b1, 1'b1, expv(IDLE, 2'b00, 1'b0, 2'd0));
    step(2'b11, 1'b1, over_val(), 1'b0, 1'b1, expv(IDLE, 2'b00, 1'b0, 2'd0));
    step(2'b00, 1'b0, 32'd0, 1'b0, 1'b0, expv(IDLE, 2'b00, 1'b0, 2'd0));
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front(); got = obs_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset: got st/pe/tr/rc=%0d/%b/%b/%0d want %0d/%b/%b/%0d",
                 got[7:5], got[4:3], got[2], got[1:0], want[7:5], want[4:3], want[2], want[1:0]);
      end
    end
  endtask

  task automatic test_power_on();
    logic [7:0] got, want;
    step(2'b11, 1'b0, 32'd0, 1'b0, 1'b0, expv(ON, 2'b11, 1'b0, 2'd0));
    step(2'b11, 1'b1, 32'd1000, 1'b0, 1'b0, expv(ON, 2'b11, 1'b0, 2'd0));
    step(2'b01, 1'b1, 32'($urandom_range(1000, 0)), 1'b0, 1'b0, expv(ON, 2'b01, 1'b0, 2'd0));
    step(2'b10, 1'b0, 32'd0, 1'b0, 1'b0, expv(ON, 2'b10, 1'b0, 2'd0));
    step(2'b11, 1'b0, 32'd0, 1'b0, 1'b0, expv(ON, 2'b11, 1'b0, 2'd0));
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front(); got = obs_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL power_on: got st/pe/tr/rc=%0d/%b/%b/%0d want %0d/%b/%b/%0d",
                 got[7:5], got[4:3], got[2], got[1:0], want[7:5], want[4:3], want[2], want[1:0]);
      end
    end
  endtask

  task automatic test_trip_cooldown();
    logic [7:0] got, want;
    trip_seq(2'd0, 1'b0, 1001, 5000);
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front(); got = obs_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL trip_cooldown: got st/pe/tr/rc=%0d/%b/%b/%0d want %0d/%b/%b/%0d",
                 got[7:5], got[4:3], got[2], got[1:0], want[7:5], want[4:3], want[2], want[1:0]);
      end
    end
  endtask

  task automatic test_release();
    logic [7:0] got, want;
    step(2'b11, 1'b1, over_val(), 1'b0, 1'b0, expv(OVER, 2'b11, 1'b0, 2'd1));
    step(2'b11, 1'b0, 32'd0, 1'b0, 1'b0, expv(OVER, 2'b11, 1'b0, 2'd1));
    step(2'b11, 1'b0, 32'd0, 1'b0, 1'b0, expv(OVER, 2'b11, 1'b0, 2'd1));
    step(2'b11, 1'b1, 32'd850, 1'b0, 1'b0, expv(ON, 2'b11, 1'b0, 2'd1));
    step(2'b11, 1'b1, 32'd1001, 1'b0, 1'b0, expv(OVER, 2'b11, 1'b0, 2'd1));
    step(2'b01, 1'b1, 32'd901, 1'b0, 1'b0, expv(OVER, 2'b01, 1'b0, 2'd1));
    step(2'b11, 1'b1, 32'd900, 1'b0, 1'b0, expv(ON, 2'b11, 1'b0, 2'd1));
    step(2'b11, 1'b1, 32'($urandom_range(900, 0)), 1'b0, 1'b0, expv(ON, 2'b11, 1'b0, 2'd1));
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front(); got = obs_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL release: got st/pe/tr/rc=%0d/%b/%b/%0d want %0d/%b/%b/%0d",
                 got[7:5], got[4:3], got[2], got[1:0], want[7:5], want[4:3], want[2], want[1:0]);
      end
    end
  endtask

  task automatic test_power_off();
    logic [7:0] got, want;
    step(2'b11, 1'b1, over_val(), 1'b0, 1'b0, expv(OVER, 2'b11, 1'b0, 2'd1));
    step(2'b00, 1'b1, 32'd100, 1'b0, 1'b0, expv(IDLE, 2'b00, 1'b0, 2'd0));
    step(2'b00, 1'b1, over_val(), 1'b0, 1'b0, expv(IDLE, 2'b00, 1'b0, 2'd0));
    step(2'b11, 1'b1, over_val(), 1'b0, 1'b0, expv(ON, 2'b11, 1'b0, 2'd0));
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front(); got = obs_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL power_off: got st/pe/tr/rc=%0d/%b/%b/%0d want %0d/%b/%b/%0d",
                 got[7:5], got[4:3], got[2], got[1:0], want[7:5], want[4:3], want[2], want[1:0]);
      end
    end
  endtask

  task automatic test_between();
    logic [7:0] got, want;
    trip_seq(2'd0, 1'b0, 901, 1000);
    step(2'b11, 1'b0, 32'd0, 1'b1, 1'b0, expv(ON, 2'b11, 1'b0, 2'd0));
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front(); got = obs_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL between: got st/pe/tr/rc=%0d/%b/%b/%0d want %0d/%b/%b/%0d",
                 got[7:5], got[4:3], got[2], got[1:0], want[7:5], want[4:3], want[2], want[1:0]);
      end
    end
  endtask

  task automatic test_latch();
    logic [7:0] got, want;
    trip_seq(2'd0, 1'b0, 901, 5000);
    trip_seq(2'd1, 1'b0, 901, 5000);
    trip_seq(2'd2, 1'b0, 901, 5000);
    for (int i = 0; i < 100; i++)
      step(2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 32'($urandom_range(5000, 0)),
           1'b0, 1'b0, expv(LATCH, 2'b00, 1'b1, 2'd2));
    step(2'b11, 1'b0, 32'd0, 1'b1, 1'b0, expv(IDLE, 2'b00, 1'b0, 2'd0));
    step(2'b11, 1'b0, 32'd0, 1'b0, 1'b0, expv(ON, 2'b11, 1'b0, 2'd0));
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front(); got = obs_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL latch: got st/pe/tr/rc=%0d/%b/%b/%0d want %0d/%b/%b/%0d",
                 got[7:5], got[4:3], got[2], got[1:0], want[7:5], want[4:3], want[2], want[1:0]);
      end
    end
  endtask

  task automatic test_clear_with_trip();
    logic [7:0] got, want;
    trip_seq(2'd0, 1'b0, 901, 5000);
    trip_seq(2'd1, 1'b0, 901, 5000);
    trip_seq(2'd2, 1'b1, 901, 5000);
    step(2'b11, 1'b0, 32'd0, 1'b1, 1'b0, expv(IDLE, 2'b00, 1'b0, 2'd0));
    step(2'b11, 1'b0, 32'd0, 1'b0, 1'b0, expv(ON, 2'b11, 1'b0, 2'd0));
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front(); got = obs_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL clear_with_trip: got st/pe/tr/rc=%0d/%b/%b/%0d want %0d/%b/%b/%0d",
                 got[7:5], got[4:3], got[2], got[1:0], want[7:5], want[4:3], want[2], want[1:0]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] got, want;
    step(2'b11, 1'b1, over_val(), 1'b0, 1'b0, expv(OVER, 2'b11, 1'b0, 2'd0));
    for (int i = 0; i < 3; i++)
      step(2'b11, 1'b1, over_val(), 1'b0, 1'b0, expv(OVER, 2'b11, 1'b0, 2'd0));
    step(2'b11, 1'b0, 32'd0, 1'b0, 1'b0, expv(COOL, 2'b00, 1'b0, 2'd1));
    for (int i = 0; i < 3; i++)
      step(2'b11, 1'b0, 32'd0, 1'b0, 1'b0, expv(COOL, 2'b00, 1'b0, 2'd1));
    step(2'b11, 1'b0, 32'd0, 1'b0, 1'b1, expv(IDLE, 2'b00, 1'b0, 2'd0));
    step(2'b11, 1'b0, 32'd0, 1'b0, 1'b0, expv(ON, 2'b11, 1'b0, 2'd0));
    step(2'b11, 1'b1, over_val(), 1'b0, 1'b0, expv(OVER, 2'b11, 1'b0, 2'd0));
    step(2'b11, 1'b1, over_val(), 1'b0, 1'b0, expv(OVER, 2'b11, 1'b0, 2'd0));
    step(2'b11, 1'b1, over_val(), 1'b0, 1'b1, expv(IDLE, 2'b00, 1'b0, 2'd0));
    step(2'b11, 1'b0, 32'd0, 1'b0, 1'b0, expv(ON, 2'b11, 1'b0, 2'd0));
    trip_seq(2'd0, 1'b0, 1001, 5000);
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front(); got = obs_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid_op: got st/pe/tr/rc=%0d/%b/%b/%0d want %0d/%b/%b/%0d",
                 got[7:5], got[4:3], got[2], got[1:0], want[7:5], want[4:3], want[2], want[1:0]);
      end
    end
  endtask

  initial begin
    reset               = 1'b1;
    bus.power_request   = 2'b00;
    bus.current_valid   = 1'b0;
    bus.current_average = 32'd0;
    bus.clear_latch     = 1'b0;
    test_reset();
    test_power_on();
    test_trip_cooldown();
    test_release();
    test_power_off();
    test_between();
    test_latch();
    test_clear_with_trip();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
